// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel-array constants and readout controller state encoding
package pixel_pkg;

    localparam int PIXEL_DEFAULT_BIT_DEPTH = 8;
    localparam int PIXEL_FLAG_BITS         = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        CAPTURE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } readout_state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_readout_controller_if.sv
// pixel_readout_controller_if: valid/ready stream of captured pixel groups
interface pixel_readout_controller_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic                  OUT_FIRST;
    logic                  OUT_LAST;

    modport master (output OUT_DATA, OUT_VALID, OUT_FIRST, OUT_LAST, input OUT_READY);
    modport slave  (input OUT_DATA, OUT_VALID, OUT_FIRST, OUT_LAST, output OUT_READY);
endinterface

// File: rtl/readout_fifo.sv
// readout_fifo: small power-of-2 FIFO whose head entry is presented from a register
module readout_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  SYSTEM_CLK,
    input  logic                  SYSTEM_RESET,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]         count_n;
    logic                  do_push, do_pop;

    assign full     = count == CW'(DEPTH);
    assign empty    = !valid;
    assign do_pop   = pop && valid;
    assign do_push  = push && (!full || do_pop);
    assign rd_ptr_n = rd_ptr + AW'(do_pop);
    assign count_n  = count + CW'(do_push) - CW'(do_pop);

    // storage array; contents are don't-care until written, so no reset
    always_ff @(posedge SYSTEM_CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers, occupancy and the registered head (bypass when the new head is being written now)
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            valid  <= count_n != '0;
            dout   <= (do_push && rd_ptr_n == wr_ptr) ? din : mem[rd_ptr_n];
        end
    end

endmodule

// File: rtl/pixel_readout_controller.sv
// pixel_readout_controller: walks pixel groups out of the array into a buffered valid/ready stream
module pixel_readout_controller
    import pixel_pkg::*;
#(
    parameter int WIDTH                  = 2,
    parameter int HEIGHT                 = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH              = PIXEL_DEFAULT_BIT_DEPTH,
    parameter int FIFO_DEPTH             = 4,
    localparam int N                     = WIDTH * HEIGHT / OUTPUT_BUS_PIXEL_WIDTH,
    localparam int SW                    = sel_width(N),
    localparam int GW                    = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH,
    localparam int CW                    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    SYSTEM_CLK,
    input  logic                    SYSTEM_RESET,
    input  logic                    READ_RESET,
    input  logic                    READ_CLK_IN,
    input  logic [GW-1:0]           PIXEL_DATA,
    output logic [SW-1:0]           READ_SELECT,
    output logic                    READ_ENABLE,
    output logic                    FRAME_DONE,
    output logic                    FRAME_ERROR,
    pixel_readout_controller_if.master stream
);

    readout_state_e                state, state_n;
    logic [SW-1:0]                 g, g_n;
    logic [GW+PIXEL_FLAG_BITS-1:0] head;
    logic [CW-1:0]                 count;
    logic prev, armed, start, err, push, pop, clear, full, empty;

    // armed only after READ_CLK_IN has been seen low, so a level already high out of reset never starts a frame
    assign start       = READ_CLK_IN && !prev && armed;
    assign pop         = !empty && stream.OUT_READY;
    assign clear       = READ_RESET || err;
    assign READ_SELECT = g;
    assign stream.OUT_DATA  = head[GW+1:2];
    assign stream.OUT_FIRST = head[1];
    assign stream.OUT_LAST  = head[0];

    // next-state: READ_RESET overrides everything, losing READ_CLK_IN mid-frame aborts with an error
    always_comb begin
        state_n = state;
        g_n     = g;
        err     = 1'b0;
        push    = 1'b0;
        if (READ_RESET) begin
            state_n = IDLE;
            g_n     = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_n = SELECT;
                        g_n     = '0;
                    end
                end
                SELECT: begin
                    if (!READ_CLK_IN) begin
                        err     = 1'b1;
                        state_n = IDLE;
                        g_n     = '0;
                    end else begin
                        state_n = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!READ_CLK_IN) begin
                        err     = 1'b1;
                        state_n = IDLE;
                        g_n     = '0;
                    end else if (!full || pop) begin
                        push = 1'b1;
                        if (g == SW'(N - 1)) begin
                            state_n = DRAIN;
                        end else begin
                            g_n     = g + SW'(1);
                            state_n = SELECT;
                        end
                    end
                end
                DRAIN: begin
                    if (count == '0) state_n = DONE;
                end
                DONE: begin
                    state_n = IDLE;
                    g_n     = '0;
                end
                default: begin
                    state_n = IDLE;
                    g_n     = '0;
                end
            endcase
        end
    end

    // state, group index, edge detector and registered array/frame outputs
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state       <= IDLE;
            g           <= '0;
            prev        <= 1'b0;
            armed       <= 1'b0;
            READ_ENABLE <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_ERROR <= 1'b0;
        end else begin
            state       <= state_n;
            g           <= g_n;
            prev        <= READ_CLK_IN;
            armed       <= armed || !READ_CLK_IN;
            READ_ENABLE <= state_n == SELECT || state_n == CAPTURE;
            FRAME_DONE  <= state_n == DONE;
            FRAME_ERROR <= err;
        end
    end

    readout_fifo #(
        .DATA_WIDTH (GW + PIXEL_FLAG_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .SYSTEM_CLK   (SYSTEM_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .din          ({PIXEL_DATA, g == '0, g == SW'(N - 1)}),
        .dout         (head),
        .valid        (stream.OUT_VALID),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

endmodule

// File: tb/tb_pixel_readout_controller.sv
// tb_pixel_readout_controller: directed vectors and corner-case sequences for the readout controller
module tb_pixel_readout_controller;

    logic        clk = 1'b0, rst = 1'b1, rr = 1'b0, rc_a = 1'b0, rc_b = 1'b0;
    logic [15:0] pix_a, pix_b;
    logic [0:0]  sel_a;
    logic [1:0]  sel_b;
    logic        en_a, en_b, done_a, done_b, err_a, err_b;
    int          checks = 0, errors = 0, nd_a = 0, nd_b = 0, ne_a = 0;
    logic [17:0] q_a [$];
    logic [17:0] q_b [$];

    typedef struct {
        logic        clk_in, ready, en;
        logic [0:0]  sel;
        logic        valid;
        logic [15:0] data;
        logic        first, last, done;
    } vec_t;
    vec_t vec [11];

    always #5 clk = ~clk;

    pixel_readout_controller_if #(.DATA_WIDTH(16)) if_a ();
    pixel_readout_controller_if #(.DATA_WIDTH(16)) if_b ();

    function automatic logic [15:0] pb(input logic [1:0] g);
        return 16'h11A0 + 16'h1111 * 16'(g);
    endfunction

    assign pix_a = sel_a[0] ? 16'hC3D4 : 16'hA1B2;
    assign pix_b = pb(sel_b);

    pixel_readout_controller dut_a (
        .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .READ_RESET(rr), .READ_CLK_IN(rc_a),
        .PIXEL_DATA(pix_a), .READ_SELECT(sel_a), .READ_ENABLE(en_a),
        .FRAME_DONE(done_a), .FRAME_ERROR(err_a), .stream(if_a.master)
    );

    pixel_readout_controller #(.HEIGHT(4), .FIFO_DEPTH(2)) dut_b (
        .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .READ_RESET(rr), .READ_CLK_IN(rc_b),
        .PIXEL_DATA(pix_b), .READ_SELECT(sel_b), .READ_ENABLE(en_b),
        .FRAME_DONE(done_b), .FRAME_ERROR(err_b), .stream(if_b.master)
    );

    always @(negedge clk) begin
        if (if_a.OUT_VALID && if_a.OUT_READY) q_a.push_back({if_a.OUT_DATA, if_a.OUT_FIRST, if_a.OUT_LAST});
        if (if_b.OUT_VALID && if_b.OUT_READY) q_b.push_back({if_b.OUT_DATA, if_b.OUT_FIRST, if_b.OUT_LAST});
        if (done_a) nd_a++;
        if (done_b) nd_b++;
        if (err_a) ne_a++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec = '{
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA1B2, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC3D4, 1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}
        };
        if_a.OUT_READY = 1'b1;
        if_b.OUT_READY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", {sel_a, en_a, if_a.OUT_VALID, if_a.OUT_FIRST, if_a.OUT_LAST, if_a.OUT_DATA, done_a, err_a}, 0);
        check("reset_b", {sel_b, en_b, if_b.OUT_VALID, if_b.OUT_FIRST, if_b.OUT_LAST, if_b.OUT_DATA, done_b, err_b}, 0);
        #3 rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            rc_a = vec[i].clk_in;
            if_a.OUT_READY = vec[i].ready;
            tick();
            check($sformatf("vec%0d_ctl", i), {en_a, sel_a, if_a.OUT_VALID, done_a, err_a},
                  {vec[i].en, vec[i].sel, vec[i].valid, vec[i].done, 1'b0});
            if (vec[i].valid)
                check($sformatf("vec%0d_beat", i), {if_a.OUT_DATA, if_a.OUT_FIRST, if_a.OUT_LAST},
                      {vec[i].data, vec[i].first, vec[i].last});
        end
        check("vec_done_count", nd_a, 1);

        rc_a = 1'b1;
        if_a.OUT_READY = 1'b0;
        repeat (3) tick();
        check("abort_valid_before", if_a.OUT_VALID, 1);
        rc_a = 1'b0;
        tick();
        check("abort_err_pulse", err_a, 1);
        check("abort_valid_cleared", if_a.OUT_VALID, 0);
        check("abort_enable_off", en_a, 0);
        tick();
        check("abort_err_one_cycle", err_a, 0);
        repeat (3) tick();
        check("abort_no_done", nd_a, 1);
        check("abort_err_count", ne_a, 1);

        rc_a = 1'b1;
        repeat (5) tick();
        check("drain_state_a", {en_a, if_a.OUT_VALID, if_a.OUT_DATA, if_a.OUT_FIRST}, {1'b0, 1'b1, 16'hA1B2, 1'b1});
        if_a.OUT_READY = 1'b1;
        tick();
        check("drain_one_left", {if_a.OUT_VALID, if_a.OUT_DATA, if_a.OUT_FIRST, if_a.OUT_LAST}, {1'b1, 16'hC3D4, 1'b0, 1'b1});
        if_a.OUT_READY = 1'b0;
        rr = 1'b1;
        tick();
        rr = 1'b0;
        check("rr_cleared", {if_a.OUT_VALID, en_a, done_a, err_a}, 0);
        tick();
        check("rr_no_done", done_a, 0);
        check("rr_done_count", nd_a, 1);
        check("rr_err_count", ne_a, 1);
        q_a.delete();
        rc_a = 1'b0;
        if_a.OUT_READY = 1'b1;
        tick();
        rc_a = 1'b1;
        begin
            int n = 0;
            while (!done_a && n < 20) begin
                tick();
                n++;
            end
        end
        check("rr_frame_done", done_a, 1);
        tick();
        check("rr_beats", q_a.size(), 2);
        if (q_a.size() == 2) begin
            check("rr_beat0", q_a[0], {16'hA1B2, 1'b1, 1'b0});
            check("rr_beat1", q_a[1], {16'hC3D4, 1'b0, 1'b1});
        end
        check("rr_done_count2", nd_a, 2);

        rc_b = 1'b1;
        repeat (8) tick();
        check("stall_sel", sel_b, 2);
        check("stall_en", en_b, 1);
        check("stall_head", {if_b.OUT_VALID, if_b.OUT_DATA, if_b.OUT_FIRST, if_b.OUT_LAST}, {1'b1, pb(2'd0), 1'b1, 1'b0});
        check("stall_count", dut_b.u_fifo.count, 2);
        if_b.OUT_READY = 1'b1;
        tick();
        check("full_pushpop_count", dut_b.u_fifo.count, 2);
        check("full_pushpop_sel", sel_b, 3);
        check("full_pushpop_head", {if_b.OUT_DATA, if_b.OUT_FIRST, if_b.OUT_LAST}, {pb(2'd1), 1'b0, 1'b0});
        check("full_pushpop_beats", q_b.size(), 1);
        begin
            int n = 0;
            while (!done_b && n < 20) begin
                tick();
                n++;
            end
        end
        check("stall_frame_done", done_b, 1);
        tick();
        check("stall_beats", q_b.size(), 4);
        for (int i = 0; i < 4 && i < q_b.size(); i++)
            check($sformatf("stall_beat%0d", i), q_b[i], {pb(2'(i)), i == 0, i == 3});
        check("stall_done_count", nd_b, 1);

        rc_a = 1'b0;
        tick();
        rc_a = 1'b1;
        repeat (2) tick();
        check("capture_en", en_a, 1);
        #3 rst = 1'b1;
        #1;
        check("async_reset_a", {sel_a, en_a, if_a.OUT_VALID, if_a.OUT_FIRST, if_a.OUT_LAST, if_a.OUT_DATA, done_a, err_a}, 0);
        check("async_reset_b", {sel_b, en_b, if_b.OUT_VALID, done_b, err_b}, 0);
        #2 rst = 1'b0;
        repeat (4) tick();
        check("no_start_high", {en_a, if_a.OUT_VALID}, 0);
        check("no_start_done", nd_a, 2);
        rc_a = 1'b0;
        tick();
        rc_a = 1'b1;
        tick();
        check("restart_after_toggle", {en_a, sel_a}, {1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_readout_controller.md
PIXEL_READOUT_CONTROLLER -- requirements
Module: pixel_readout_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 2, pixel columns.
REQ-002 SHALL have parameter HEIGHT, default 2, pixel rows.
REQ-003 SHALL have parameter OUTPUT_BUS_PIXEL_WIDTH, default 2, pixels per group/beat; WIDTH*HEIGHT must be a multiple.
REQ-004 SHALL have parameter BIT_DEPTH, default 8, bits per pixel.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-006 SHALL use reset SYSTEM_RESET, asynchronous, active-high; clock SYSTEM_CLK.
REQ-007 SHALL have ports: SYSTEM_CLK in 1, clock; SYSTEM_RESET in 1, async reset.
REQ-008 SHALL have ports: READ_RESET in 1 (sync abort/clear); READ_CLK_IN in 1 (read phase active, level).
REQ-009 SHALL have port PIXEL_DATA in OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH, selected pixel group from array.
REQ-010 SHALL have ports READ_SELECT out clog2(N) (N=WIDTH*HEIGHT/OUTPUT_BUS_PIXEL_WIDTH, min width 1), group index; READ_ENABLE out 1, array drive enable.
REQ-011 SHALL have ports OUT_DATA out OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH; OUT_VALID out 1; OUT_READY in 1; OUT_FIRST out 1; OUT_LAST out 1.
REQ-012 SHALL have ports FRAME_DONE out 1 (pulse); FRAME_ERROR out 1 (pulse).

Function
REQ-013 SHALL implement states IDLE, SELECT, CAPTURE, DRAIN, DONE.
REQ-014 IDLE->SELECT on posedge where READ_CLK_IN=1 and its registered previous value=0 (rising detect); group index g=0.
REQ-015 SELECT: READ_SELECT=g, READ_ENABLE=1 for one settling cycle, then ->CAPTURE.
REQ-016 CAPTURE: READ_SELECT/READ_ENABLE held; if FIFO can accept (count<FIFO_DEPTH, or pop same cycle), push {PIXEL_DATA, first=(g==0), last=(g==N-1)}; else stay in CAPTURE (stall).
REQ-017 After push: g<N-1 -> g+1, ->SELECT; g==N-1 -> DRAIN, READ_ENABLE=0.
REQ-018 DRAIN: wait until FIFO empty, ->DONE; DONE: FRAME_DONE=1 one cycle, ->IDLE.
REQ-019 Throughput: one group per 2 cycles unstalled; group g at OUT_DATA 1 cycle after its push (registered head).
REQ-020 Output handshake: transfer iff OUT_VALID&&OUT_READY; OUT_DATA/OUT_FIRST/OUT_LAST stable while OUT_VALID&&!OUT_READY; OUT_VALID=1 iff FIFO non-empty.
REQ-021 Simultaneous push and pop with FIFO full: both occur, count unchanged.
REQ-022 READ_CLK_IN=0 in SELECT/CAPTURE before last push: discard FIFO, FRAME_ERROR=1 one cycle, ->IDLE, no FRAME_DONE.
REQ-023 READ_CLK_IN remaining high after DONE SHALL NOT restart a frame (needs new rising edge).
REQ-024 READ_RESET=1 in any state: next cycle state=IDLE, g=0, FIFO empty, no FRAME_DONE/FRAME_ERROR; dominates all other events.
REQ-025 READ_SELECT wraps never: g SHALL NOT exceed N-1.

Reset
REQ-026 SYSTEM_RESET SHALL asynchronously force: state=IDLE, g=0, FIFO empty, READ_SELECT=0, READ_ENABLE=0, OUT_VALID=0, OUT_DATA=0, OUT_FIRST=0, OUT_LAST=0, FRAME_DONE=0, FRAME_ERROR=0, edge-detect register=0.
REQ-027 Reset deasserted with READ_CLK_IN already high SHALL NOT start a frame.

Structure
REQ-028 State enum and state encoding SHALL reside in shared package pixel_pkg alongside existing pixel state constants.
REQ-029 FIFO SHALL be sub-module readout_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-030 All outputs SHALL be registered; logic on posedge SYSTEM_CLK only.

Verification
REQ-031 Defaults, OUT_READY=1, PIXEL_DATA=0xA1B2 for g=0, 0xC3D4 for g=1, READ_CLK_IN 0->1 -> two beats 0xA1B2 (FIRST) then 0xC3D4 (LAST), FRAME_DONE one cycle after FIFO empties.
REQ-032 OUT_READY=0 whole frame, FIFO_DEPTH=2 with N=4 (HEIGHT=4) -> CAPTURE stalls at g=2, READ_SELECT held 2; release OUT_READY -> all 4 beats in order, no loss/duplication.
REQ-033 READ_CLK_IN dropped after first push -> FRAME_ERROR pulse, OUT_VALID=0 next cycle, no FRAME_DONE.
REQ-034 READ_RESET pulsed in DRAIN with 1 entry pending -> IDLE, OUT_VALID=0, no FRAME_DONE; next rising READ_CLK_IN reads full frame normally.
REQ-035 SYSTEM_RESET asserted mid-CAPTURE (async, between clock edges) -> all outputs at reset values immediately; READ_CLK_IN held high -> no frame until it toggles.
REQ-036 Full FIFO with simultaneous push and pop -> count stays FIFO_DEPTH, ordering preserved.
